// File: rtl/cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter
//
// Two-port front end for the unified cache request port. Port 0 carries
// instruction-fetch reads and port 1 carries loads/stores. Both are merged
// onto the single valid/ready request bus of the cache. The owner of every
// accepted request is recorded in an in-order tag FIFO, and each in-order
// cache response is steered back combinationally to the port that issued it.
//
// Optional feature (compile-time macro ARB_ROUND_ROBIN_EN):
//   defined   : on contention, grant the port not granted at the last
//               handshake (round-robin pointer updated on handshakes only)
//   undefined : fixed priority, port 1 over port 0; no RR pointer exists
//
// Parameters
//   MAX_OUTSTANDING  requests accepted by the cache but not yet answered
//   ADDR_W           request address width
//   DATA_W           request/response data width (wstrb is DATA_W/8 bits)
//
// Ports
//   clk_i, rst_i                      clock, async active-high reset
//   p0_req_valid_i/addr_i/ready_o     ifetch request channel
//   p0_resp_valid_o/value_o           ifetch response (single-cycle pulse)
//   p1_req_valid_i/value_i/addr_i/
//     wstrb_i/ready_o                 load/store request channel
//   p1_resp_valid_o/value_o           load/store response (pulse)
//   req_valid_o/value_o/addr_o/
//     wstrb_o, req_ready_i            merged request to the cache
//   resp_valid_i/value_i              in-order response from the cache
//   err_o                             sticky: response seen with no owner
// ---------------------------------------------------------------------------
module cache_req_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  p0_req_valid_i,
    input  logic [ADDR_W-1:0]     p0_req_addr_i,
    output logic                  p0_req_ready_o,
    output logic                  p0_resp_valid_o,
    output logic [DATA_W-1:0]     p0_resp_value_o,

    input  logic                  p1_req_valid_i,
    input  logic [DATA_W-1:0]     p1_req_value_i,
    input  logic [ADDR_W-1:0]     p1_req_addr_i,
    input  logic [DATA_W/8-1:0]   p1_req_wstrb_i,
    output logic                  p1_req_ready_o,
    output logic                  p1_resp_valid_o,
    output logic [DATA_W-1:0]     p1_resp_value_o,

    output logic                  req_valid_o,
    output logic [DATA_W-1:0]     req_value_o,
    output logic [ADDR_W-1:0]     req_addr_o,
    output logic [DATA_W/8-1:0]   req_wstrb_o,
    input  logic                  req_ready_i,

    input  logic                  resp_valid_i,
    input  logic [DATA_W-1:0]     resp_value_i,

    output logic                  err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OCC_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_OUTSTANDING);

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Pointer increment with wrap at MAX_OUTSTANDING (depth need not be a
    // power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic                 tag_mem [0:MAX_OUTSTANDING-1];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [OCC_W-1:0]     occ;
    logic                 lock_q;
    logic                 lock_gnt_q;
    logic                 err_q;

    logic                 contend_pick;
    logic                 grant;
    logic                 granted_valid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 issue;
    logic                 handshake;
    logic                 pop;
    logic                 stray_resp;
    logic                 head;

`ifdef ARB_ROUND_ROBIN_EN
    // Port preferred on the next contended cycle; it is the port that did
    // not win the most recent handshake. Starts at port 1 after reset.
    logic rr_pref_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_pref_q <= PORT1;
        end else if (handshake) begin
            rr_pref_q <= ~grant;
        end
    end

    assign contend_pick = rr_pref_q;
`else
    assign contend_pick = PORT1;
`endif

    // -----------------------------------------------------------------------
    // Arbitration: a locked grant wins over everything so that a stalled
    // request keeps its payload stable until the cache accepts it.
    // -----------------------------------------------------------------------
    always_comb begin
        grant = PORT0;
        if (lock_q) begin
            grant = lock_gnt_q;
        end else if (p1_req_valid_i && p0_req_valid_i) begin
            grant = contend_pick;
        end else if (p1_req_valid_i) begin
            grant = PORT1;
        end
    end

    assign fifo_full     = (occ == OCC_FULL);
    assign fifo_empty    = (occ == '0);
    assign granted_valid = grant ? p1_req_valid_i : p0_req_valid_i;
    // Full is judged on the registered occupancy: a pop in the same cycle
    // does not free a slot until the next cycle.
    assign issue         = granted_valid && !fifo_full;
    assign handshake     = issue && req_ready_i;
    assign pop           = resp_valid_i && !fifo_empty;
    assign stray_resp    = resp_valid_i && fifo_empty;
    assign head          = tag_mem[rd_ptr];

    // -----------------------------------------------------------------------
    // Outputs. Combinational outputs are forced low while reset is held.
    // -----------------------------------------------------------------------
    assign req_valid_o     = issue && !rst_i;
    assign req_addr_o      = rst_i ? '0 : (grant ? p1_req_addr_i : p0_req_addr_i);
    assign req_value_o     = (rst_i || !grant) ? '0 : p1_req_value_i;
    assign req_wstrb_o     = (rst_i || !grant) ? '0 : p1_req_wstrb_i;

    assign p0_req_ready_o  = !rst_i && (grant == PORT0) && req_ready_i && !fifo_full;
    assign p1_req_ready_o  = !rst_i && (grant == PORT1) && req_ready_i && !fifo_full;

    assign p0_resp_valid_o = !rst_i && pop && (head == PORT0);
    assign p1_resp_valid_o = !rst_i && pop && (head == PORT1);
    assign p0_resp_value_o = p0_resp_valid_o ? resp_value_i : '0;
    assign p1_resp_value_o = p1_resp_valid_o ? resp_value_i : '0;

    assign err_o           = err_q;

    // -----------------------------------------------------------------------
    // Tag FIFO storage: contents need no reset, pointers/occupancy govern it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            lock_q     <= 1'b0;
            lock_gnt_q <= PORT0;
            err_q      <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({handshake, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase

            if (handshake) begin
                lock_q <= 1'b0;
            end else if (issue) begin
                lock_q     <= 1'b1;
                lock_gnt_q <= grant;
            end

            if (stray_resp) begin
                err_q <= 1'b1;
            end
        end
    end

    // STRB_W documents the byte-enable width relation used in the port list.
    if (STRB_W * 8 != DATA_W) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_req_arbiter
//
// Self-checking bench for cache_req_arbiter. A queue-based reference model
// tracks the owners of outstanding requests, the lock and the sticky error,
// and predicts every output from the inputs of the current cycle. Directed
// scenarios cover reset, single read, contention, backpressure, ordering
// with a full tag FIFO and stray responses; a randomized run follows.
// Inputs change just after the falling edge and outputs are sampled 1 ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_cache_req_arbiter;

    localparam int MAXO = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req_valid_i;
    logic [AW-1:0] p0_req_addr_i;
    logic          p0_req_ready_o;
    logic          p0_resp_valid_o;
    logic [DW-1:0] p0_resp_value_o;
    logic          p1_req_valid_i;
    logic [DW-1:0] p1_req_value_i;
    logic [AW-1:0] p1_req_addr_i;
    logic [SW-1:0] p1_req_wstrb_i;
    logic          p1_req_ready_o;
    logic          p1_resp_valid_o;
    logic [DW-1:0] p1_resp_value_o;
    logic          req_valid_o;
    logic [DW-1:0] req_value_o;
    logic [AW-1:0] req_addr_o;
    logic [SW-1:0] req_wstrb_o;
    logic          req_ready_i;
    logic          resp_valid_i;
    logic [DW-1:0] resp_value_i;
    logic          err_o;

    always #5 clk = ~clk;

    cache_req_arbiter #(
        .MAX_OUTSTANDING(MAXO),
        .ADDR_W         (AW),
        .DATA_W         (DW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .p0_req_valid_i (p0_req_valid_i),
        .p0_req_addr_i  (p0_req_addr_i),
        .p0_req_ready_o (p0_req_ready_o),
        .p0_resp_valid_o(p0_resp_valid_o),
        .p0_resp_value_o(p0_resp_value_o),
        .p1_req_valid_i (p1_req_valid_i),
        .p1_req_value_i (p1_req_value_i),
        .p1_req_addr_i  (p1_req_addr_i),
        .p1_req_wstrb_i (p1_req_wstrb_i),
        .p1_req_ready_o (p1_req_ready_o),
        .p1_resp_valid_o(p1_resp_valid_o),
        .p1_resp_value_o(p1_resp_value_o),
        .req_valid_o    (req_valid_o),
        .req_value_o    (req_value_o),
        .req_addr_o     (req_addr_o),
        .req_wstrb_o    (req_wstrb_o),
        .req_ready_i    (req_ready_i),
        .resp_valid_i   (resp_valid_i),
        .resp_value_i   (resp_value_i),
        .err_o          (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int q[$];      // owners of outstanding requests, oldest first
    int pref;      // port preferred on contention (round-robin build)
    bit lk;        // a stalled request holds the grant
    int lkp;
    bit err_m;

    // Predicted outputs for the current cycle
    int            exp_gnt;
    bit            exp_req_valid, exp_p0_ready, exp_p1_ready;
    logic [AW-1:0] exp_req_addr;
    logic [DW-1:0] exp_req_value;
    logic [SW-1:0] exp_req_wstrb;
    bit            exp_p0_rv, exp_p1_rv;
    logic [DW-1:0] exp_p0_rval, exp_p1_rval;
    bit            exp_err;

    task automatic model_reset();
        q.delete();
        pref  = 1;
        lk    = 1'b0;
        lkp   = 0;
        err_m = 1'b0;
    endtask

    // Apply one cycle of inputs and predict the outputs from the model.
    task automatic drive(input bit p0v, input logic [AW-1:0] p0a,
                         input bit p1v, input logic [DW-1:0] p1d,
                         input logic [AW-1:0] p1a, input logic [SW-1:0] p1w,
                         input bit rdy, input bit rv, input logic [DW-1:0] rval);
        bit full;
        p0_req_valid_i = p0v;  p0_req_addr_i = p0a;
        p1_req_valid_i = p1v;  p1_req_value_i = p1d;
        p1_req_addr_i  = p1a;  p1_req_wstrb_i = p1w;
        req_ready_i    = rdy;
        resp_valid_i   = rv;   resp_value_i = rval;

        if (lk)              exp_gnt = lkp;
        else if (p0v && p1v) exp_gnt = RR ? pref : 1;
        else if (p1v)        exp_gnt = 1;
        else                 exp_gnt = 0;
        full          = (q.size() == MAXO);
        exp_req_valid = ((exp_gnt == 1) ? p1v : p0v) && !full;
        exp_p0_ready  = (exp_gnt == 0) && rdy && !full;
        exp_p1_ready  = (exp_gnt == 1) && rdy && !full;
        exp_req_addr  = (exp_gnt == 1) ? p1a : p0a;
        exp_req_value = (exp_gnt == 1) ? p1d : '0;
        exp_req_wstrb = (exp_gnt == 1) ? p1w : '0;
        exp_p0_rv     = rv && (q.size() > 0) && (q[0] == 0);
        exp_p1_rv     = rv && (q.size() > 0) && (q[0] == 1);
        exp_p0_rval   = exp_p0_rv ? rval : '0;
        exp_p1_rval   = exp_p1_rv ? rval : '0;
        exp_err       = err_m;
        #1;
    endtask

    // Commit the model for this cycle and move to the next falling edge.
    task automatic advance();
        bit hs;
        hs = exp_req_valid && req_ready_i;
        if (resp_valid_i) begin
            if (q.size() > 0) void'(q.pop_front());
            else              err_m = 1'b1;
        end
        if (hs) begin
            q.push_back(exp_gnt);
            pref = 1 - exp_gnt;
            lk   = 1'b0;
        end else if (exp_req_valid) begin
            lk  = 1'b1;
            lkp = exp_gnt;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, '0, 0, '0, '0, '0, 0, 0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h40, 1, 32'h11, 32'h80, 4'hF, 1, 1, 32'h99);
            n_tests++;
            if ({req_valid_o, req_value_o, req_addr_o, req_wstrb_o, p0_req_ready_o,
                 p1_req_ready_o, p0_resp_valid_o, p0_resp_value_o, p1_resp_valid_o,
                 p1_resp_value_o, err_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: req_valid=%b addr=%h p0_rdy=%b p1_rdy=%b err=%b required all 0",
                         i, req_valid_o, req_addr_o, p0_req_ready_o, p1_req_ready_o, err_o);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        model_reset();
        drive(1, 32'h40, 1, 32'h11, 32'h80, 4'hF, 1, 0, '0);
        n_tests++;
        if (p1_req_ready_o !== 1'b1 || p0_req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_grant: p0_rdy=%b p1_rdy=%b required p0=0 p1=1",
                     p0_req_ready_o, p1_req_ready_o);
        end
        n_tests++;
        if (req_addr_o !== 32'h80) begin
            n_fail++;
            $display("FAIL reset_first_addr: got %h required 00000080", req_addr_o);
        end
        advance();
        drive(0, '0, 0, '0, '0, '0, 1, 1, 32'h5);
        n_tests++;
        if (p1_resp_valid_o !== 1'b1 || p1_resp_value_o !== 32'h5 || p0_resp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_resp: p1_rv=%b val=%h p0_rv=%b required 1/00000005/0",
                     p1_resp_valid_o, p1_resp_value_o, p0_resp_valid_o);
        end
        advance();
    endtask

    task automatic test_single_read();
        do_reset();
        drive(1, 32'h100, 0, 32'h12345678, 32'h999, 4'h3, 1, 0, '0);
        n_tests++;
        if (p0_req_ready_o !== 1'b1 || req_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_accept: p0_rdy=%b req_valid=%b required 1/1", p0_req_ready_o, req_valid_o);
        end
        n_tests++;
        if (req_addr_o !== 32'h100 || req_value_o !== '0 || req_wstrb_o !== '0) begin
            n_fail++;
            $display("FAIL single_payload: addr=%h value=%h wstrb=%h required 00000100/0/0",
                     req_addr_o, req_value_o, req_wstrb_o);
        end
        advance();
        drive(0, '0, 0, '0, '0, '0, 1, 1, 32'hDEADBEEF);
        n_tests++;
        if (p0_resp_valid_o !== 1'b1 || p0_resp_value_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_resp_p0: rv=%b val=%h required 1/deadbeef", p0_resp_valid_o, p0_resp_value_o);
        end
        n_tests++;
        if (p1_resp_valid_o !== 1'b0 || p1_resp_value_o !== '0) begin
            n_fail++;
            $display("FAIL single_resp_p1_silent: rv=%b val=%h required 0/0", p1_resp_valid_o, p1_resp_value_o);
        end
        advance();
        drive(0, '0, 0, '0, '0, '0, 1, 0, '0);
        n_tests++;
        if (p0_resp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp_pulse: p0_rv=%b required 0", p0_resp_valid_o);
        end
        advance();
    endtask

    task automatic test_contention();
        bit exp1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h1000 + i, 1, 32'hA0 + i, 32'h2000 + i, 4'hF, 1,
                  q.size() > 0, $urandom);
            exp1 = RR ? (i % 2 == 0) : 1'b1;
            n_tests++;
            if (p1_req_ready_o !== exp1 || p0_req_ready_o !== !exp1) begin
                n_fail++;
                $display("FAIL contention_grant %0d: p0_rdy=%b p1_rdy=%b required p1_rdy=%b",
                         i, p0_req_ready_o, p1_req_ready_o, exp1);
            end
            n_tests++;
            if (p0_resp_valid_o !== exp_p0_rv || p1_resp_valid_o !== exp_p1_rv ||
                p0_resp_value_o !== exp_p0_rval || p1_resp_value_o !== exp_p1_rval) begin
                n_fail++;
                $display("FAIL contention_resp %0d: p0 %b/%h p1 %b/%h required p0 %b/%h p1 %b/%h",
                         i, p0_resp_valid_o, p0_resp_value_o, p1_resp_valid_o, p1_resp_value_o,
                         exp_p0_rv, exp_p0_rval, exp_p1_rv, exp_p1_rval);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(i >= 2, 32'h300, 1, 32'h55AA, 32'h200, 4'hF, 0, 0, '0);
            n_tests++;
            if (req_valid_o !== 1'b1 || req_addr_o !== 32'h200 || req_value_o !== 32'h55AA ||
                req_wstrb_o !== 4'hF || p1_req_ready_o !== 1'b0 || p0_req_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stable %0d: v=%b addr=%h val=%h wstrb=%h rdy=%b%b required 1/200/55aa/f/00",
                         i, req_valid_o, req_addr_o, req_value_o, req_wstrb_o, p0_req_ready_o, p1_req_ready_o);
            end
            advance();
        end
        drive(1, 32'h300, 1, 32'h55AA, 32'h200, 4'hF, 1, 0, '0);
        n_tests++;
        if (p1_req_ready_o !== 1'b1 || p0_req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_p1_first: p0_rdy=%b p1_rdy=%b required 0/1", p0_req_ready_o, p1_req_ready_o);
        end
        advance();
        drive(1, 32'h300, 0, '0, '0, '0, 1, 0, '0);
        n_tests++;
        if (p0_req_ready_o !== 1'b1 || req_addr_o !== 32'h300) begin
            n_fail++;
            $display("FAIL bp_p0_next: p0_rdy=%b addr=%h required 1/00000300", p0_req_ready_o, req_addr_o);
        end
        advance();

        // A stalled port 0 request keeps the grant when port 1 arrives.
        do_reset();
        drive(1, 32'h600, 0, '0, '0, '0, 0, 0, '0);
        advance();
        drive(1, 32'h600, 1, 32'h77, 32'h700, 4'h3, 0, 0, '0);
        n_tests++;
        if (req_addr_o !== 32'h600 || req_wstrb_o !== '0 || req_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_lock_hold: addr=%h wstrb=%h v=%b required 00000600/0/1",
                     req_addr_o, req_wstrb_o, req_valid_o);
        end
        advance();
        drive(1, 32'h600, 1, 32'h77, 32'h700, 4'h3, 1, 0, '0);
        n_tests++;
        if (p0_req_ready_o !== 1'b1 || p1_req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_lock_release: p0_rdy=%b p1_rdy=%b required 1/0", p0_req_ready_o, p1_req_ready_o);
        end
        advance();
        drive(0, '0, 1, 32'h77, 32'h700, 4'h3, 1, 0, '0);
        n_tests++;
        if (p1_req_ready_o !== 1'b1 || req_addr_o !== 32'h700) begin
            n_fail++;
            $display("FAIL bp_after_lock: p1_rdy=%b addr=%h required 1/00000700", p1_req_ready_o, req_addr_o);
        end
        advance();
    endtask

    task automatic test_full_order();
        do_reset();
        drive(1, 32'h1000, 0, '0, '0, '0, 1, 0, '0);
        n_tests++;
        if (p0_req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_accept_a: p0_rdy=%b required 1", p0_req_ready_o);
        end
        advance();
        drive(0, '0, 1, '0, 32'h2000, '0, 1, 0, '0);
        n_tests++;
        if (p1_req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_accept_b: p1_rdy=%b required 1", p1_req_ready_o);
        end
        advance();
        drive(1, 32'h3000, 0, '0, '0, '0, 1, 0, '0);
        n_tests++;
        if (req_valid_o !== 1'b0 || p0_req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_stall: req_valid=%b p0_rdy=%b required 0/0", req_valid_o, p0_req_ready_o);
        end
        advance();
        drive(1, 32'h3000, 0, '0, '0, '0, 1, 1, 32'hAAAA);
        n_tests++;
        if (req_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL full_stall_with_pop: req_valid=%b required 0", req_valid_o);
        end
        n_tests++;
        if (p0_resp_valid_o !== 1'b1 || p0_resp_value_o !== 32'hAAAA || p1_resp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_resp_a: p0 %b/%h p1 %b required p0 1/0000aaaa p1 0",
                     p0_resp_valid_o, p0_resp_value_o, p1_resp_valid_o);
        end
        advance();
        drive(1, 32'h3000, 0, '0, '0, '0, 1, 1, 32'hBBBB);
        n_tests++;
        if (p0_req_ready_o !== 1'b1 || p1_resp_valid_o !== 1'b1 || p1_resp_value_o !== 32'hBBBB ||
            p0_resp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_push_pop: p0_rdy=%b p1_rv=%b val=%h p0_rv=%b required 1/1/0000bbbb/0",
                     p0_req_ready_o, p1_resp_valid_o, p1_resp_value_o, p0_resp_valid_o);
        end
        advance();
        drive(0, '0, 1, '0, 32'h4000, '0, 1, 0, '0);
        n_tests++;
        if (p1_req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_accept_d: p1_rdy=%b required 1", p1_req_ready_o);
        end
        advance();
        drive(1, 32'h5000, 0, '0, '0, '0, 1, 0, '0);
        n_tests++;
        if (req_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL full_count_kept: req_valid=%b required 0", req_valid_o);
        end
        advance();
        drive(0, '0, 0, '0, '0, '0, 1, 1, 32'hCCCC);
        n_tests++;
        if (p0_resp_valid_o !== 1'b1 || p0_resp_value_o !== 32'hCCCC || p1_resp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_resp_c: p0 %b/%h p1 %b required p0 1/0000cccc p1 0",
                     p0_resp_valid_o, p0_resp_value_o, p1_resp_valid_o);
        end
        advance();
        drive(0, '0, 0, '0, '0, '0, 1, 1, 32'hDDDD);
        n_tests++;
        if (p1_resp_valid_o !== 1'b1 || p1_resp_value_o !== 32'hDDDD || p0_resp_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_resp_d: p1 %b/%h p0 %b required p1 1/0000dddd p0 0",
                     p1_resp_valid_o, p1_resp_value_o, p0_resp_valid_o);
        end
        advance();
    endtask

    task automatic test_stray_resp();
        do_reset();
        drive(0, '0, 0, '0, '0, '0, 1, 1, 32'h1234);
        n_tests++;
        if (p0_resp_valid_o !== 1'b0 || p1_resp_valid_o !== 1'b0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_no_pulse: p0_rv=%b p1_rv=%b err=%b required 0/0/0",
                     p0_resp_valid_o, p1_resp_valid_o, err_o);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 0, '0, '0, '0, 1, 0, '0);
            n_tests++;
            if (err_o !== 1'b1) begin
                n_fail++; $display("FAIL stray_err_sticky %0d: err=%b required 1", i, err_o);
            end
            advance();
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (err_o !== 1'b0) begin
            n_fail++; $display("FAIL stray_err_async_clear: err=%b required 0", err_o);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(0, '0, 0, '0, '0, '0, 1, 0, '0);
        n_tests++;
        if (err_o !== 1'b0) begin
            n_fail++; $display("FAIL stray_err_after_reset: err=%b required 0", err_o);
        end
        advance();
    endtask

    task automatic test_random();
        bit rv;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 2) == 0) && ((q.size() > 0) || ($urandom_range(0, 15) == 0));
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom, $urandom,
                  SW'($urandom), $urandom_range(0, 3) != 0, rv, $urandom);
            n_tests++;
            if (req_valid_o !== exp_req_valid || p0_req_ready_o !== exp_p0_ready ||
                p1_req_ready_o !== exp_p1_ready) begin
                n_fail++;
                $display("FAIL rand_handshake %0d: v=%b rdy=%b%b required v=%b rdy=%b%b",
                         i, req_valid_o, p0_req_ready_o, p1_req_ready_o,
                         exp_req_valid, exp_p0_ready, exp_p1_ready);
            end
            n_tests++;
            if (req_addr_o !== exp_req_addr || req_value_o !== exp_req_value ||
                req_wstrb_o !== exp_req_wstrb) begin
                n_fail++;
                $display("FAIL rand_payload %0d: %h/%h/%h required %h/%h/%h", i, req_addr_o,
                         req_value_o, req_wstrb_o, exp_req_addr, exp_req_value, exp_req_wstrb);
            end
            n_tests++;
            if (p0_resp_valid_o !== exp_p0_rv || p1_resp_valid_o !== exp_p1_rv ||
                p0_resp_value_o !== exp_p0_rval || p1_resp_value_o !== exp_p1_rval) begin
                n_fail++;
                $display("FAIL rand_resp %0d: p0 %b/%h p1 %b/%h required p0 %b/%h p1 %b/%h",
                         i, p0_resp_valid_o, p0_resp_value_o, p1_resp_valid_o, p1_resp_value_o,
                         exp_p0_rv, exp_p0_rval, exp_p1_rv, exp_p1_rval);
            end
            n_tests++;
            if (err_o !== exp_err) begin
                n_fail++; $display("FAIL rand_err %0d: err=%b required %b", i, err_o, exp_err);
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        drive(0, '0, 0, '0, '0, '0, 0, 0, '0);
        @(negedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_full_order();
        test_stray_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
